// File: rtl/sa_autosa_cmac_reg_group_ctrl.sv
// Ping-pong controller for the two CMAC dual register groups: pointer/op_en ownership,
// CSB write steering and read mux, datapath launch on the consumer group and retire on done.
module sa_autosa_cmac_reg_group_ctrl #(
  parameter int unsigned      OFS_W      = 12,
  parameter int unsigned      DATA_W     = 32,
  parameter logic [OFS_W-1:0] PTR_OFS    = OFS_W'(0),
  parameter logic [OFS_W-1:0] STATUS_OFS = OFS_W'(4)
) (
  input  logic              autosa_core_clk,
  input  logic              autosa_core_rstn,
  input  logic              req_wr_en,
  input  logic              req_rd_en,
  input  logic [OFS_W-1:0]  req_offset,
  input  logic [DATA_W-1:0] req_wr_data,
  output logic              rsp_rd_valid,
  output logic [DATA_W-1:0] rsp_rd_data,
  output logic [OFS_W-1:0]  grp_offset,
  output logic [DATA_W-1:0] grp_wr_data,
  output logic              grp0_wr_en,
  output logic              grp1_wr_en,
  input  logic [DATA_W-1:0] grp0_rd_data,
  input  logic [DATA_W-1:0] grp1_rd_data,
  input  logic              grp0_op_en_trigger,
  input  logic              grp1_op_en_trigger,
  output logic              grp0_op_en,
  output logic              grp1_op_en,
  input  logic              grp0_cosa_mode,
  input  logic              grp1_cosa_mode,
  input  logic [1:0]        grp0_precision,
  input  logic [1:0]        grp1_precision,
  output logic              dp_op_start,
  output logic              dp_cosa_mode,
  output logic [1:0]        dp_precision,
  input  logic              dp_op_done,
  output logic [1:0]        done_intr
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]        state_q, state_d;
  logic              producer_q, producer_d;
  logic              consumer_q, consumer_d;
  logic [1:0]        op_en_q, op_en_d;
  logic              dp_op_start_q, dp_op_start_d;
  logic              dp_cosa_mode_q, dp_cosa_mode_d;
  logic [1:0]        dp_precision_q, dp_precision_d;
  logic [1:0]        done_intr_q, done_intr_d;
  logic              rsp_rd_valid_q, rsp_rd_valid_d;
  logic [DATA_W-1:0] rsp_rd_data_q, rsp_rd_data_d;

  logic              is_ptr_c;
  logic              is_status_c;
  logic              grp_wr_c;
  logic [1:0]        st0_c;
  logic [1:0]        st1_c;
  logic [DATA_W-1:0] rd_mux_c;

  // Register decode and group write steering (combinational toward the groups)
  always_comb begin
    is_ptr_c    = (req_offset == PTR_OFS);
    is_status_c = (req_offset == STATUS_OFS);
    grp_wr_c    = req_wr_en && !is_ptr_c && !is_status_c;
  end

  assign grp_offset  = req_offset;
  assign grp_wr_data = req_wr_data;
  assign grp0_wr_en  = grp_wr_c && !producer_q;
  assign grp1_wr_en  = grp_wr_c && producer_q;

  // Per-group status: running takes precedence over pending
  always_comb begin
    st0_c = 2'd0;
    st1_c = 2'd0;
    if (state_q == ST_BUSY && !consumer_q) st0_c = 2'd1;
    else if (op_en_q[0])                   st0_c = 2'd2;
    if (state_q == ST_BUSY && consumer_q)  st1_c = 2'd1;
    else if (op_en_q[1])                   st1_c = 2'd2;
  end

  always_comb begin
    rd_mux_c = '0;
    if (is_ptr_c) begin
      rd_mux_c[0]  = producer_q;
      rd_mux_c[16] = consumer_q;
    end else if (is_status_c) begin
      rd_mux_c[1:0]   = st0_c;
      rd_mux_c[17:16] = st1_c;
    end else begin
      rd_mux_c = producer_q ? grp1_rd_data : grp0_rd_data;
    end
  end

  // Next-state: IDLE/BUSY launch-retire plus pointer, op_en and read response
  always_comb begin
    state_d        = state_q;
    producer_d     = producer_q;
    consumer_d     = consumer_q;
    op_en_d        = op_en_q;
    dp_op_start_d  = 1'b0;
    dp_cosa_mode_d = dp_cosa_mode_q;
    dp_precision_d = dp_precision_q;
    done_intr_d    = 2'b00;
    rsp_rd_valid_d = req_rd_en;
    rsp_rd_data_d  = req_rd_en ? rd_mux_c : rsp_rd_data_q;

    if (req_wr_en && is_ptr_c) producer_d = req_wr_data[0];

    if (state_q == ST_IDLE) begin
      if (op_en_q[consumer_q]) begin
        state_d        = ST_BUSY;
        dp_op_start_d  = 1'b1;
        dp_cosa_mode_d = consumer_q ? grp1_cosa_mode : grp0_cosa_mode;
        dp_precision_d = consumer_q ? grp1_precision : grp0_precision;
      end
    end else begin
      if (dp_op_done) begin
        state_d                  = ST_IDLE;
        op_en_d[consumer_q]      = 1'b0;
        done_intr_d[consumer_q]  = 1'b1;
        consumer_d               = !consumer_q;
      end
    end

    // A trigger in the retire cycle re-queues the group
    if (grp0_op_en_trigger && req_wr_data[0]) op_en_d[0] = 1'b1;
    if (grp1_op_en_trigger && req_wr_data[0]) op_en_d[1] = 1'b1;
  end

  always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
    if (!autosa_core_rstn) begin
      state_q        <= ST_IDLE;
      producer_q     <= 1'b0;
      consumer_q     <= 1'b0;
      op_en_q        <= 2'b00;
      dp_op_start_q  <= 1'b0;
      dp_cosa_mode_q <= 1'b0;
      dp_precision_q <= 2'b01;
      done_intr_q    <= 2'b00;
      rsp_rd_valid_q <= 1'b0;
      rsp_rd_data_q  <= '0;
    end else begin
      state_q        <= state_d;
      producer_q     <= producer_d;
      consumer_q     <= consumer_d;
      op_en_q        <= op_en_d;
      dp_op_start_q  <= dp_op_start_d;
      dp_cosa_mode_q <= dp_cosa_mode_d;
      dp_precision_q <= dp_precision_d;
      done_intr_q    <= done_intr_d;
      rsp_rd_valid_q <= rsp_rd_valid_d;
      rsp_rd_data_q  <= rsp_rd_data_d;
    end
  end

  assign rsp_rd_valid = rsp_rd_valid_q;
  assign rsp_rd_data  = rsp_rd_data_q;
  assign grp0_op_en   = op_en_q[0];
  assign grp1_op_en   = op_en_q[1];
  assign dp_op_start  = dp_op_start_q;
  assign dp_cosa_mode = dp_cosa_mode_q;
  assign dp_precision = dp_precision_q;
  assign done_intr    = done_intr_q;

endmodule

// File: tb/tb_sa_autosa_cmac_reg_group_ctrl.sv
// Bench for the CMAC register-group controller: directed ping-pong scenarios then random
// CSB/done traffic, all checked against a transaction-level model of pointers, queue and config.
module tb_sa_autosa_cmac_reg_group_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_wr_en, req_rd_en;
  logic [11:0] req_offset;
  logic [31:0] req_wr_data;
  logic        rsp_rd_valid;
  logic [31:0] rsp_rd_data;
  logic [11:0] grp_offset;
  logic [31:0] grp_wr_data;
  logic        grp0_wr_en, grp1_wr_en;
  logic [31:0] grp0_rd_data, grp1_rd_data;
  logic        grp0_op_en_trigger, grp1_op_en_trigger;
  logic        grp0_op_en, grp1_op_en;
  logic        grp0_cosa_mode, grp1_cosa_mode;
  logic [1:0]  grp0_precision, grp1_precision;
  logic        dp_op_start, dp_cosa_mode;
  logic [1:0]  dp_precision;
  logic        dp_op_done;
  logic [1:0]  done_intr;

  int n_cmp;
  int n_bad;

  always #5 clk = ~clk;

  sa_autosa_cmac_reg_group_ctrl dut (
    .autosa_core_clk    (clk),
    .autosa_core_rstn   (rstn),
    .req_wr_en          (req_wr_en),
    .req_rd_en          (req_rd_en),
    .req_offset         (req_offset),
    .req_wr_data        (req_wr_data),
    .rsp_rd_valid       (rsp_rd_valid),
    .rsp_rd_data        (rsp_rd_data),
    .grp_offset         (grp_offset),
    .grp_wr_data        (grp_wr_data),
    .grp0_wr_en         (grp0_wr_en),
    .grp1_wr_en         (grp1_wr_en),
    .grp0_rd_data       (grp0_rd_data),
    .grp1_rd_data       (grp1_rd_data),
    .grp0_op_en_trigger (grp0_op_en_trigger),
    .grp1_op_en_trigger (grp1_op_en_trigger),
    .grp0_op_en         (grp0_op_en),
    .grp1_op_en         (grp1_op_en),
    .grp0_cosa_mode     (grp0_cosa_mode),
    .grp1_cosa_mode     (grp1_cosa_mode),
    .grp0_precision     (grp0_precision),
    .grp1_precision     (grp1_precision),
    .dp_op_start        (dp_op_start),
    .dp_cosa_mode       (dp_cosa_mode),
    .dp_precision       (dp_precision),
    .dp_op_done         (dp_op_done),
    .done_intr          (done_intr)
  );

  // Minimal dual-group stand-in: config register at 0x00c (cosa=bit12, precision=[1:0]),
  // op_enable write at 0x008 raises the trigger.
  logic [31:0] cfg0, cfg1;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cfg0 <= '0;
      cfg1 <= '0;
    end else begin
      if (grp0_wr_en && grp_offset == 12'h00c) cfg0 <= grp_wr_data;
      if (grp1_wr_en && grp_offset == 12'h00c) cfg1 <= grp_wr_data;
    end
  end
  assign grp0_rd_data       = cfg0;
  assign grp1_rd_data       = cfg1;
  assign grp0_cosa_mode     = cfg0[12];
  assign grp1_cosa_mode     = cfg1[12];
  assign grp0_precision     = cfg0[1:0];
  assign grp1_precision     = cfg1[1:0];
  assign grp0_op_en_trigger = grp0_wr_en && grp_offset == 12'h008;
  assign grp1_op_en_trigger = grp1_wr_en && grp_offset == 12'h008;

  // Reference model state
  bit        m_prod, m_cons, m_busy, m_start, m_cosa, m_rvalid;
  bit [1:0]  m_op_en, m_done, m_prec;
  bit [31:0] m_rdata;
  bit [31:0] m_cfg [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_prod = 0; m_cons = 0; m_busy = 0; m_start = 0; m_cosa = 0; m_rvalid = 0;
    m_op_en = 2'b00; m_done = 2'b00; m_prec = 2'b01; m_rdata = '0;
    m_cfg[0] = '0; m_cfg[1] = '0;
  endtask

  function automatic bit [1:0] m_we();
    if (req_wr_en && req_offset != 12'h000 && req_offset != 12'h004)
      return m_prod ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  function automatic bit [31:0] m_rd_val(input logic [11:0] off);
    bit [1:0] st [2];
    if (off == 12'h000) return {15'b0, m_cons, 15'b0, m_prod};
    if (off == 12'h004) begin
      for (int g = 0; g < 2; g++) begin
        if (m_busy && m_cons == 1'(g)) st[g] = 2'd1;
        else if (m_op_en[g])           st[g] = 2'd2;
        else                           st[g] = 2'd0;
      end
      return {14'b0, st[1], 14'b0, st[0]};
    end
    return m_cfg[m_prod];
  endfunction

  // One clock of the model: queue a group, launch the consumer, retire and flip
  task automatic model_clock();
    bit [1:0] we, trig, n_op;
    bit       retire, launch;
    we     = m_we();
    trig   = (req_offset == 12'h008) ? we : 2'b00;
    retire = m_busy && dp_op_done;
    launch = !m_busy && m_op_en[m_cons];
    m_rvalid = req_rd_en;
    if (req_rd_en) m_rdata = m_rd_val(req_offset);
    n_op = m_op_en;
    if (retire) n_op[m_cons] = 1'b0;
    for (int g = 0; g < 2; g++) if (trig[g] && req_wr_data[0]) n_op[g] = 1'b1;
    m_done = 2'b00;
    if (retire) m_done[m_cons] = 1'b1;
    m_start = launch;
    if (launch) begin
      m_cosa = m_cfg[m_cons][12];
      m_prec = m_cfg[m_cons][1:0];
    end
    if (retire) m_busy = 0;
    else if (launch) m_busy = 1;
    if (retire) m_cons = ~m_cons;
    if (req_wr_en && req_offset == 12'h000) m_prod = req_wr_data[0];
    for (int g = 0; g < 2; g++) if (we[g] && req_offset == 12'h00c) m_cfg[g] = req_wr_data;
    m_op_en = n_op;
  endtask

  task automatic check_regs();
    chk("rsp_rd_valid", 32'(rsp_rd_valid), 32'(m_rvalid));
    chk("rsp_rd_data", rsp_rd_data, m_rdata);
    chk("op_en", 32'({grp1_op_en, grp0_op_en}), 32'(m_op_en));
    chk("dp_op_start", 32'(dp_op_start), 32'(m_start));
    chk("dp_cosa_mode", 32'(dp_cosa_mode), 32'(m_cosa));
    chk("dp_precision", 32'(dp_precision), 32'(m_prec));
    chk("done_intr", 32'(done_intr), 32'(m_done));
  endtask

  task automatic step();
    bit [1:0] we;
    @(negedge clk);
    we = m_we();
    chk("grp_wr_en", 32'({grp1_wr_en, grp0_wr_en}), 32'(we));
    chk("grp_offset", 32'(grp_offset), 32'(req_offset));
    model_clock();
    @(posedge clk);
    #1;
    check_regs();
  endtask

  task automatic set_idle();
    req_wr_en = 0; req_rd_en = 0; req_offset = '0; req_wr_data = '0; dp_op_done = 0;
  endtask

  task automatic wr(input logic [11:0] off, input logic [31:0] d);
    set_idle(); req_wr_en = 1; req_offset = off; req_wr_data = d; step(); set_idle();
  endtask

  task automatic rd(input logic [11:0] off);
    set_idle(); req_rd_en = 1; req_offset = off; step(); set_idle();
  endtask

  task automatic done_pulse();
    set_idle(); dp_op_done = 1; step(); set_idle();
  endtask

  task automatic idle();
    set_idle(); step();
  endtask

  // Asynchronous reset mid-cycle; outputs must drop without waiting for a clock
  task automatic do_reset();
    @(negedge clk);
    #2 rstn = 0;
    set_idle();
    #1;
    chk("rst_rsp_rd_valid", 32'(rsp_rd_valid), 32'h0);
    chk("rst_rsp_rd_data", rsp_rd_data, 32'h0);
    chk("rst_op_en", 32'({grp1_op_en, grp0_op_en}), 32'h0);
    chk("rst_dp_op_start", 32'(dp_op_start), 32'h0);
    chk("rst_dp_cosa_mode", 32'(dp_cosa_mode), 32'h0);
    chk("rst_dp_precision", 32'(dp_precision), 32'h1);
    chk("rst_done_intr", 32'(done_intr), 32'h0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #3 rstn = 1;
  endtask

  initial begin
    int unsigned r;
    n_cmp = 0;
    n_bad = 0;
    rstn  = 1;
    set_idle();
    model_reset();
    #1;

    // Reset values and pointer/status reads
    do_reset();
    rd(12'h000); chk("t1_ptr", rsp_rd_data, 32'h0);
    rd(12'h004); chk("t1_status", rsp_rd_data, 32'h0);
    rd(12'h00c); chk("t1_grp0_rd", rsp_rd_data, 32'h0);
    chk("t1_dp_precision", 32'(dp_precision), 32'h1);

    // Single launch/retire on group 0
    wr(12'h00c, 32'h0000_1001);
    wr(12'h008, 32'h1);
    chk("t2_op_en", 32'({grp1_op_en, grp0_op_en}), 32'h1);
    idle();
    chk("t2_start", 32'(dp_op_start), 32'h1);
    chk("t2_cosa", 32'(dp_cosa_mode), 32'h1);
    chk("t2_prec", 32'(dp_precision), 32'h1);
    rd(12'h00c); chk("t2_cfg_rd", rsp_rd_data, 32'h0000_1001);
    done_pulse();
    chk("t2_done", 32'(done_intr), 32'h1);
    chk("t2_op_en_clr", 32'({grp1_op_en, grp0_op_en}), 32'h0);
    rd(12'h000); chk("t2_ptr", rsp_rd_data, 32'h0001_0000);

    // Ping-pong: arm group 1 while group 0 runs
    do_reset();
    wr(12'h00c, 32'h0000_0002);
    wr(12'h008, 32'h1);
    idle();
    chk("t3_start0", 32'(dp_op_start), 32'h1);
    wr(12'h000, 32'h1);
    wr(12'h00c, 32'h0000_1003);
    wr(12'h008, 32'h1);
    rd(12'h004); chk("t3_status", rsp_rd_data, 32'h0002_0001);
    done_pulse();
    chk("t3_done0", 32'(done_intr), 32'h1);
    idle();
    chk("t3_start1", 32'(dp_op_start), 32'h1);
    chk("t3_cosa1", 32'(dp_cosa_mode), 32'h1);
    chk("t3_prec1", 32'(dp_precision), 32'h3);

    // Trigger with data 0, and done while idle
    done_pulse();
    chk("t4_done1", 32'(done_intr), 32'h2);
    wr(12'h008, 32'h0);
    chk("t4_op_en", 32'({grp1_op_en, grp0_op_en}), 32'h0);
    idle();
    chk("t4_no_start", 32'(dp_op_start), 32'h0);
    done_pulse();
    chk("t4_idle_done", 32'(done_intr), 32'h0);
    rd(12'h000); chk("t4_ptr", rsp_rd_data, 32'h0000_0001);

    // Retire and re-trigger group 0 in the same cycle
    wr(12'h000, 32'h0);
    wr(12'h008, 32'h1);
    idle();
    wr(12'h000, 32'h1);
    wr(12'h008, 32'h1);
    wr(12'h000, 32'h0);
    set_idle(); req_wr_en = 1; req_offset = 12'h008; req_wr_data = 32'h1; dp_op_done = 1;
    step(); set_idle();
    chk("t5_done0", 32'(done_intr), 32'h1);
    chk("t5_op_en0", 32'(grp0_op_en), 32'h1);
    idle();
    chk("t5_start1", 32'(dp_op_start), 32'h1);
    done_pulse();
    chk("t5_done1", 32'(done_intr), 32'h2);
    idle();
    chk("t5_restart0", 32'(dp_op_start), 32'h1);
    rd(12'h004); chk("t5_status", rsp_rd_data, 32'h0000_0001);

    // Reset while busy; a later done must be ignored
    do_reset();
    done_pulse();
    chk("t6_done_ignored", 32'(done_intr), 32'h0);
    idle();
    chk("t6_no_start", 32'(dp_op_start), 32'h0);

    // Random CSB and datapath traffic
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      set_idle();
      r = $urandom_range(0, 9);
      req_offset = 12'(4 * $urandom_range(0, 4));
      if (r < 4) begin
        req_wr_en   = 1;
        req_wr_data = $urandom;
      end else if (r < 7) begin
        req_rd_en = 1;
      end
      dp_op_done = ($urandom_range(0, 3) == 0);
      step();
    end
    set_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
